// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter.
// Holds the FSM state enum, owner codes, default sizes and a range helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam int MAX_WAIT_DEF  = 4;
    localparam int MEM_WORDS_DEF = 4096;

    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] words
    );
        return addr < words;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core fetch/data ports plus the memory-side bus.
// slave = arbiter view, master = core + memory view.
interface mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        i_err;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;

    logic        en_mem;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_valid, i_err,
        input  d_req, d_addr, d_wdata, d_wmask,
        output d_rdata, d_valid, d_err,
        output en_mem, mem_addr, mem_rstrb, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_valid, i_err,
        output d_req, d_addr, d_wdata, d_wmask,
        input  d_rdata, d_valid, d_err,
        input  en_mem, mem_addr, mem_rstrb, mem_wdata, mem_wmask,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first grant select with a fetch starvation counter.
// Ports: clk, resetn, idle_i, i_req_i, d_req_i in; grant_i, grant_d out.
module mem_arb_prio #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic idle_i,
    input  logic i_req_i,
    input  logic d_req_i,
    output logic grant_i,
    output logic grant_d
);

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;
    logic       starve;

    assign starve  = (wait_cnt_q == 4'(MAX_WAIT));

    // Fetch wins only when it has lost MAX_WAIT times in a row.
    assign grant_i = idle_i & i_req_i & (~d_req_i | starve);
    assign grant_d = idle_i & d_req_i & ~(i_req_i & starve);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (idle_i) begin
            if (!i_req_i || grant_i) begin
                wait_cnt_d = 4'd0;
            end else if (grant_d && !starve) begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store onto one memory port.
// Ports: clk, resetn, bus (mem_arbiter_if.slave). Option: MEM_ARB_RANGE_CHECK_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);

`ifdef MEM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        err_q, err_d;
    logic        en_q, en_d;
    logic        rstrb_q, rstrb_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        idle;
    logic        grant_i;
    logic        grant_d;
    logic [31:0] sel_addr;
    logic        oor;
    logic        resp;
    logic [31:0] rdata;

    assign idle = (state_q == IDLE);

    mem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk     (clk),
        .resetn  (resetn),
        .idle_i  (idle),
        .i_req_i (bus.i_req),
        .d_req_i (bus.d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign sel_addr = grant_i ? bus.i_addr : bus.d_addr;
    assign oor = RANGE_EN &&
                 !in_range(sel_addr, 32'(MEM_WORDS));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        err_d   = err_q;
        // Memory-side strobes default low so every access is one cycle.
        en_d    = 1'b0;
        rstrb_d = 1'b0;
        wmask_d = 4'd0;
        addr_d  = 32'd0;
        wdata_d = 32'd0;
        unique case (state_q)
            IDLE: begin
                owner_d = OWN_NONE;
                err_d   = 1'b0;
                if (grant_i || grant_d) begin
                    owner_d = grant_i ? OWN_I : OWN_D;
                    err_d   = oor;
                    if (oor) begin
                        // Out-of-range: answer directly, memory untouched.
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                        en_d    = 1'b1;
                        addr_d  = sel_addr;
                        if (grant_i) begin
                            rstrb_d = 1'b1;
                        end else begin
                            wmask_d = bus.d_wmask;
                            wdata_d = bus.d_wdata;
                            rstrb_d = (bus.d_wmask == 4'd0);
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            rstrb_q <= 1'b0;
            wmask_q <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            en_q    <= en_d;
            rstrb_q <= rstrb_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.en_mem    = en_q;
    assign bus.mem_rstrb = rstrb_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign resp  = (state_q == RESP);
    assign rdata = err_q ? 32'd0 : bus.mem_rdata;

    assign bus.i_valid = resp && (owner_q == OWN_I);
    assign bus.d_valid = resp && (owner_q == OWN_D);
    assign bus.i_rdata = bus.i_valid ? rdata : 32'd0;
    assign bus.d_rdata = bus.d_valid ? rdata : 32'd0;
    assign bus.i_err   = bus.i_valid & err_q;
    assign bus.d_err   = bus.d_valid & err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port word-addressed program/data memory between the core's instruction-fetch port and its load/store port. Requests are arbitrated and sequenced into one memory access at a time, driving the memory's enable, word address, read strobe, write data and byte mask. Each read response or write completion is returned to the requester that owns the access. Sits between the RISC-V core's two bus ports and the memory block.

Parameters:
MEM_WORDS, 4096, memory depth in 32-bit words; the range-check feature uses it.
MAX_WAIT, 4, consecutive arbitration losses after which fetch is forced to win (1..15).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held high, with i_addr stable, until i_valid
i_addr  in  32  fetch word address
i_rdata  out  32  fetch read data; valid only when i_valid=1, 0 otherwise
i_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held high, with inputs stable, until d_valid
d_addr  in  32  data word address
d_wdata  in  32  store data
d_wmask  in  4  byte write mask; 0 = read
d_rdata  out  32  load data; valid only when d_valid=1, 0 otherwise
d_valid  out  1  one-cycle data completion pulse (read or write)
d_err  out  1  out-of-range flag, qualified by d_valid
i_err  out  1  out-of-range flag, qualified by i_valid
en_mem  out  1  memory enable
mem_addr  out  32  memory word address
mem_rstrb  out  1  read strobe
mem_wdata  out  32  memory write data
mem_wmask  out  4  memory byte mask
mem_rdata  in  32  memory read data; registered, one-cycle latency

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low on resetn.
- Reset state: state=IDLE, owner=none, wait_cnt=0. All outputs are 0.
- FSM states: IDLE, ISSUE, RESP. All memory-side outputs are registered.
- IDLE, no request pending: stay in IDLE; all memory-side outputs are 0.
- IDLE, a request is pending:
  - Select the owner on the clock edge and go to ISSUE.
  - Load en_mem=1, mem_addr=owner address.
  - Fetch owner: mem_wmask=0, mem_rstrb=1.
  - Data owner: mem_wmask=d_wmask, mem_wdata=d_wdata, mem_rstrb=(d_wmask==0).
- ISSUE: lasts exactly one cycle, during which the memory samples the access. Next state is RESP. On leaving ISSUE, en_mem, mem_rstrb and mem_wmask return to 0.
- RESP:
  - Owner's valid=1 for exactly one cycle.
  - Owner's rdata = mem_rdata, combinational pass-through; for writes it is don't-care, driven as mem_rdata.
  - Next state is always IDLE.
- Timing:
  - Request visible at edge N ⇒ en_mem high in cycle N+1, valid in cycle N+2.
  - Minimum spacing between grants is 3 cycles.
- Arbitration: data has priority over fetch, except when wait_cnt==MAX_WAIT, in which case fetch wins.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on every IDLE grant to data while i_req=1.
  - Clears on a fetch grant, or when i_req=0 in IDLE.
- A requester that drops req before its valid is a protocol violation. The access still completes and valid still pulses.
- The served requester may keep req high during RESP. It is re-arbitrated from IDLE in the following cycle.
- Reset during ISSUE: en_mem and mem_wmask clear asynchronously, so no write reaches memory at the next edge. A pending valid is lost.
- Address width: all 32 address bits pass through unchanged; the memory indexes by word.

Optional Feature:
MEM_ARB_RANGE_CHECK_EN.
- Defined:
  - A granted request with address ≥ MEM_WORDS skips ISSUE: IDLE→RESP directly, with en_mem never asserted.
  - The owner's valid pulses one cycle after the grant edge, with rdata=0 and the owner's err=1.
  - In-range accesses behave as in Behaviour, with err=0.
- Not defined: no check is made; i_err and d_err are tied to 0.

Decomposition:
- Package mem_arb_pkg:
  - State enum typedef (IDLE/ISSUE/RESP).
  - Owner encoding constants (OWN_NONE, OWN_I, OWN_D).
  - Default MAX_WAIT and MEM_WORDS.
- One sub-module, mem_arb_prio:
  - Combinational data-priority select plus the registered wait_cnt starvation counter.
  - Outputs: grant_i, grant_d.

Test Plan:
- Fetch read: MEM[5]=0xDEADBEEF; i_req with i_addr=5 seen at edge 0 → en_mem=1, mem_rstrb=1, mem_wmask=0 in cycle 1; i_valid=1 with i_rdata=0xDEADBEEF in cycle 2; d_valid stays 0.
- Byte store: MEM[7]=0x11223344; d_req with d_addr=7, d_wmask=4'b0010, d_wdata=0x0000AB00 → mem_rstrb=0 and mem_wmask=0010 in ISSUE; d_valid one cycle; a read of address 7 then returns 0x1122AB44.
- Contention: i_req and d_req held high continuously, data reissued after each d_valid, MAX_WAIT=4 → grant order D,D,D,D,I,D,…; no valid pulse ever reaches the wrong requester.
- Reset mid-ISSUE: store to address 9 (MEM[9]=0) with resetn pulled low during ISSUE → en_mem=0 immediately; MEM[9] remains 0; no valid pulse; FSM in IDLE after release.
- With MEM_ARB_RANGE_CHECK_EN defined: d_req with d_addr=4096 → en_mem never 1; d_valid=1, d_err=1, d_rdata=0 one cycle after the grant edge. Without the macro: access is issued and d_err=0.
